// File: rtl/and2_arbiter.sv
// rtl/and2_arbiter.sv - round-robin arbiter in front of a registered bitwise AND unit
module and2_arbiter #(
    parameter int WIDTH = 1,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a,
    input  logic [NREQ*WIDTH-1:0] b,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [1:0]            rsp_id,
    output logic [WIDTH-1:0]      rsp_y
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t           state;
    logic [1:0]       ptr;
    logic [1:0]       owner;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    logic             win_found;
    logic [1:0]       win_idx;
    logic [1:0]       cand;

    // First set request at or above ptr, wrapping modulo 4.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr;
        cand      = ptr;
        for (int k = 0; k < 4; k++) begin
            cand = ptr + 2'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            owner     <= 2'd0;
            op_a      <= '0;
            op_b      <= '0;
            gnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 2'd0;
            rsp_y     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    gnt       <= '0;
                    rsp_valid <= 1'b0;
                    if (win_found) begin
                        gnt[win_idx] <= 1'b1;
                        op_a         <= a[win_idx*WIDTH +: WIDTH];
                        op_b         <= b[win_idx*WIDTH +: WIDTH];
                        owner        <= win_idx;
                        ptr          <= win_idx + 2'd1;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    gnt       <= '0;
                    rsp_y     <= op_a & op_b;
                    rsp_id    <= owner;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    // Response fields clear on acceptance so IDLE shows all outputs low.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_id    <= 2'd0;
                        rsp_y     <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    gnt       <= '0;
                    rsp_valid <= 1'b0;
                    rsp_id    <= 2'd0;
                    rsp_y     <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/and2_arbiter.md
AND2_ARBITER -- requirements
Module: and2_arbiter

Interface
REQ-001 Parameter WIDTH, default 1, SHALL set the bit width of each operand pair and of the result.
REQ-002 Parameter NREQ, fixed at 4, SHALL be the number of requesters; other values are unsupported.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req  input  4  SHALL be the per-requester request lines, bit i = requester i.
REQ-006 a  input  4*WIDTH  SHALL carry the operand A for each requester, slice i = a[i*WIDTH +: WIDTH].
REQ-007 b  input  4*WIDTH  SHALL carry the operand B for each requester, sliced as a.
REQ-008 gnt  output  4  SHALL be the one-hot grant, high for exactly one cycle per accepted request.
REQ-009 busy  output  1  SHALL be high whenever state is not IDLE.
REQ-010 rsp_valid  output  1  SHALL flag a valid result.
REQ-011 rsp_ready  input  1  SHALL be the consumer acceptance of the result.
REQ-012 rsp_id  output  2  SHALL be the index of the requester that owns the result.
REQ-013 rsp_y  output  WIDTH  SHALL be the result, bitwise A AND B.

Function
REQ-014 FSM states SHALL be IDLE, EXEC and RESP only; an illegal encoding SHALL return to IDLE on the next edge.
REQ-015 IDLE with req == 0 SHALL stay in IDLE with all outputs low.
REQ-016 IDLE with req != 0 at an edge SHALL pick the winner, capture its a/b slices into operand registers, set gnt[winner] and go to EXEC, all at that edge.
REQ-017 Winner SHALL be the first set req bit searching upward from ptr, modulo 4.
REQ-018 The 2-bit ptr SHALL load (winner+1) mod 4 at the grant edge; ptr 3 SHALL wrap to 0.
REQ-019 gnt SHALL be registered, high only during the EXEC cycle, and zero in every other state.
REQ-020 The EXEC edge SHALL register operand_a AND operand_b into rsp_y, register the winner into rsp_id, set rsp_valid and go to RESP (result valid 2 edges after the request is sampled).
REQ-021 In RESP, rsp_valid, rsp_id and rsp_y SHALL hold stable until an edge where rsp_ready is high; that edge SHALL clear rsp_valid and go to IDLE.
REQ-022 rsp_ready high outside RESP SHALL be ignored.
REQ-023 Requests arriving or changing during EXEC or RESP SHALL NOT be sampled; arbitration occurs only in IDLE.
REQ-024 A requester still holding req after its grant SHALL be treated as a new request at the next IDLE, subject to round-robin order.
REQ-025 Operand inputs SHALL matter only at the grant edge; later changes SHALL NOT affect rsp_y.
REQ-026 Minimum transaction spacing SHALL be 3 cycles: grant, response, and one IDLE sampling edge.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, ptr 0, gnt 0, busy 0, rsp_valid 0, rsp_id 0, rsp_y 0, and operand registers 0.
REQ-028 Reset during EXEC or RESP SHALL discard the transaction with no response produced.
REQ-029 After rst_n rises, the first sampling edge SHALL arbitrate with ptr 0.

Verification
REQ-030 Single request: WIDTH=1, req=0100, a2=1, b2=1, rsp_ready=1. Required: gnt=0100 for 1 cycle, then rsp_valid=1, rsp_id=2, rsp_y=1, then IDLE.
REQ-031 Truth table: requester 0 applies (a,b) = 00, 01, 10, 11 sequentially. Required: rsp_y = 0, 0, 0, 1 respectively.
REQ-032 Fairness: req=1111 held constant, rsp_ready=1. Required: grant order 0, 1, 2, 3, 0, with one gnt pulse every 3 cycles.
REQ-033 Wrap: ptr=3 (after a grant to 2), req=1001. Required: winner 3, then winner 0 next.
REQ-034 Backpressure: rsp_ready=0 for 5 cycles in RESP, operands changed meanwhile. Required: rsp_valid, rsp_id and rsp_y stable; no new gnt until rsp_ready=1.
REQ-035 Reset mid-op: rst_n pulsed low during RESP. Required: all outputs 0 immediately; no response after release; next grant follows the ptr=0 order.
